// File: rtl/qclk_timed_trigger.sv
// Timestamped command queue: holds commands until the qclk time base reaches
// their timestamp, then emits a one-cycle trigger; stale heads are dropped and counted.
module qclk_timed_trigger #(
    parameter int WIDTH      = 32,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         qclk_in,
    input  logic                     qclk_load,
    input  logic                     flush,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [WIDTH-1:0]         cmd_time,
    input  logic [DATA_WIDTH-1:0]    cmd_data,
    output logic                     trig_valid,
    output logic [DATA_WIDTH-1:0]    trig_data,
    output logic [WIDTH-1:0]         trig_time,
    output logic                     late_pulse,
    output logic [15:0]              late_count,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0]      time_mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  trig_valid_q, trig_valid_d;
    logic [DATA_WIDTH-1:0] trig_data_q, trig_data_d;
    logic [WIDTH-1:0]      trig_time_q, trig_time_d;
    logic                  late_pulse_q, late_pulse_d;
    logic [15:0]           late_count_q, late_count_d;

    logic                  full, push, eval, fire, late, pop;
    logic [WIDTH-1:0]      head_time, diff;
    logic [DATA_WIDTH-1:0] head_data;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign cmd_ready = !full && !flush && !rst;
    assign push      = cmd_valid && cmd_ready;

    assign head_time = time_mem[rd_ptr_q];
    assign head_data = data_mem[rd_ptr_q];

    // Modular difference read as signed keeps ordering correct across qclk rollover.
    assign diff = head_time - qclk_in;
    assign eval = (count_q != '0) && !flush && !qclk_load;
    assign fire = eval && (diff == '0);
    assign late = eval && diff[WIDTH-1];
    assign pop  = fire || late;

    always_ff @(posedge clk) begin
        if (push) begin
            time_mem[wr_ptr_q] <= cmd_time;
            data_mem[wr_ptr_q] <= cmd_data;
        end
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        trig_valid_d = fire;
        late_pulse_d = late;
        trig_data_d  = trig_data_q;
        trig_time_d  = trig_time_q;
        late_count_d = late_count_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (!push && pop) count_d = count_q - CNT_W'(1);
        end

        if (fire) begin
            trig_data_d = head_data;
            trig_time_d = head_time;
        end
        if (late && (late_count_q != 16'hFFFF))
            late_count_d = late_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            trig_valid_q <= 1'b0;
            trig_data_q  <= '0;
            trig_time_q  <= '0;
            late_pulse_q <= 1'b0;
            late_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            trig_valid_q <= trig_valid_d;
            trig_data_q  <= trig_data_d;
            trig_time_q  <= trig_time_d;
            late_pulse_q <= late_pulse_d;
            late_count_q <= late_count_d;
        end
    end

    assign trig_valid = trig_valid_q;
    assign trig_data  = trig_data_q;
    assign trig_time  = trig_time_q;
    assign late_pulse = late_pulse_q;
    assign late_count = late_count_q;
    assign count      = count_q;
    assign empty      = (count_q == '0);

endmodule
